producer_fsm_mc: RTL and testbench

//   Parametrised multi-channel stimulus producer for the pipeline test harness. It generates
//   NUM_CH independent data streams (incrementing counter or Galois LFSR), one per pipeline.

---
 rtl/producer_fsm_mc_if.sv | 27 ++
 rtl/producer_fsm_mc.sv | 159 +++++++++++++++
 tb/tb_producer_fsm_mc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/producer_fsm_mc_if.sv
// Handshake/bus bundle between the multi-channel producer and its consumer pipelines.
interface producer_fsm_mc_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 32
);
  logic                       start;
  logic                       stall;
  logic [NUM_CH-1:0]          ch_enable;
  logic                       mode;
  logic [15:0]                num_items;
  logic [NUM_CH-1:0]          flush_req;
  logic [NUM_CH*DATA_W-1:0]   data_out;
  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH-1:0]          flush;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, stall, ch_enable, mode, num_items, flush_req,
    output data_out, in_valid, flush, busy, done
  );

  modport slave (
    output start, stall, ch_enable, mode, num_items, flush_req,
    input  data_out, in_valid, flush, busy, done
  );
endinterface

// File: rtl/producer_fsm_mc.sv
// Multi-channel stimulus producer: NUM_CH counter/LFSR streams with global stall
// and per-channel flush-and-restart.
module producer_fsm_mc #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] LFSR_TAPS = 32'h8020_0003,
  parameter logic [31:0] LFSR_SEED = 32'h0000_ACE1
) (
  input logic               clk,
  input logic               reset,
  producer_fsm_mc_if.master bus
);

  localparam int unsigned CNT_W = DATA_W - 8;
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);
  localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [NUM_CH-1:0]              en_q, en_d;
  logic                           mode_q, mode_d;
  logic [15:0]                    num_q, num_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  gen_q, gen_d;
  logic [NUM_CH-1:0][15:0]        sent_q, sent_d;
  logic [NUM_CH-1:0]              valid_q, valid_d;
  logic [NUM_CH-1:0]              flush_q, flush_d;
  logic                           busy_q, done_q;
  logic                           all_idle;

  // Word 0 of channel ch: counter {ch, 0} or the per-channel LFSR seed.
  function automatic logic [DATA_W-1:0] first_word(input int unsigned ch, input logic m);
    logic [DATA_W-1:0] w;
    if (m) begin
      w = SEED ^ DATA_W'(ch + 32'd1);
    end else begin
      w = '0;
      w[DATA_W-1 -: 8] = 8'(ch);
    end
    return w;
  endfunction

  // Successor word; the counter keeps the channel tag in the top byte.
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w, input logic m);
    logic [DATA_W-1:0] n;
    if (m) begin
      n = w[0] ? ((w >> 1) ^ TAPS) : (w >> 1);
    end else begin
      n = w;
      n[CNT_W-1:0] = w[CNT_W-1:0] + CNT_W'(1);
    end
    return n;
  endfunction

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    num_d    = num_q;
    data_d   = data_q;
    gen_d    = gen_q;
    sent_d   = sent_q;
    valid_d  = valid_q;
    flush_d  = '0;
    all_idle = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          en_d    = bus.ch_enable;
          mode_d  = bus.mode;
          num_d   = bus.num_items;
          valid_d = '0;
          sent_d  = '0;
          if (bus.num_items == 16'd0 || bus.ch_enable == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (bus.ch_enable[i]) begin
                data_d[i]  = first_word(i, bus.mode);
                gen_d[i]   = next_word(data_d[i], bus.mode);
                sent_d[i]  = 16'd1;
                valid_d[i] = 1'b1;
              end
            end
          end
        end
      end

      S_RUN: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          // Flush wins over stall and over consume/load on the same edge.
          if (en_q[i] && bus.flush_req[i]) begin
            flush_d[i] = 1'b1;
            valid_d[i] = 1'b0;
            sent_d[i]  = 16'd0;
            gen_d[i]   = first_word(i, mode_q);
          end else if (en_q[i] && !(valid_q[i] && bus.stall)) begin
            if (sent_q[i] < num_q) begin
              data_d[i]  = gen_q[i];
              gen_d[i]   = next_word(gen_q[i], mode_q);
              sent_d[i]  = sent_q[i] + 16'd1;
              valid_d[i] = 1'b1;
            end else begin
              valid_d[i] = 1'b0;
            end
          end
          if (en_q[i] && (valid_d[i] || sent_d[i] < num_q)) begin
            all_idle = 1'b0;
          end
        end
        if (all_idle) begin
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      mode_q  <= 1'b0;
      num_q   <= 16'd0;
      data_q  <= '0;
      gen_q   <= '0;
      sent_q  <= '0;
      valid_q <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      data_q  <= data_d;
      gen_q   <= gen_d;
      sent_q  <= sent_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.data_out = data_q;
  assign bus.in_valid = valid_q;
  assign bus.flush    = flush_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_producer_fsm_mc.sv
// Directed self-checking bench for producer_fsm_mc (two channels, 32-bit words).
module tb_producer_fsm_mc;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  localparam logic [31:0] SEED   = 32'h0000_ACE1;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  producer_fsm_mc_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  producer_fsm_mc #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LFSR_TAPS(TAPS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ch_word(input int ch);
    return bus.data_out[ch*32 +: 32];
  endfunction

  function automatic logic [31:0] cnt_word(input int ch, input int k);
    return {8'(ch), 24'(k)};
  endfunction

  function automatic logic [31:0] lfsr_ref(input logic [31:0] w);
    return w[0] ? ((w >> 1) ^ TAPS) : (w >> 1);
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "/data"},  64'(bus.data_out), 64'd0);
    check_eq({tag, "/valid"}, 64'(bus.in_valid), 64'd0);
    check_eq({tag, "/flush"}, 64'(bus.flush), 64'd0);
    check_eq({tag, "/busy"},  64'(bus.busy), 64'd0);
    check_eq({tag, "/done"},  64'(bus.done), 64'd0);
  endtask

  // Four-word counter run with an optional stall window starting at cycle st_at.
  task automatic run_cnt(input logic [1:0] en, input int st_at, input int st_len, input string tag);
    int idx = 0;
    int c = 0;
    bus.ch_enable = en;
    bus.mode      = 1'b0;
    bus.num_items = 16'd4;
    bus.stall     = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    while (idx < 4 && c < 40) begin
      check_eq({tag, "/valid"}, 64'(bus.in_valid), 64'(en));
      check_eq({tag, "/busy"},  64'(bus.busy), 64'd1);
      for (int ch = 0; ch < 2; ch++)
        if (en[ch]) check_eq({tag, "/word"}, 64'(ch_word(ch)), 64'(cnt_word(ch, idx)));
      bus.stall = (c >= st_at && c < st_at + st_len);
      if (!bus.stall) idx++;
      tick();
      c++;
    end
    bus.stall = 1'b0;
    check_eq({tag, "/done_cycle"}, 64'(c), 64'(4 + st_len));
    check_eq({tag, "/done"},       64'(bus.done), 64'd1);
    check_eq({tag, "/busy_end"},   64'(bus.busy), 64'd0);
    check_eq({tag, "/valid_end"},  64'(bus.in_valid), 64'd0);
    tick();
    check_eq({tag, "/done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] w [2];
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.ch_enable = 2'b00;
    bus.mode      = 1'b0;
    bus.num_items = 16'd0;
    bus.flush_req = 2'b00;
    tick();
    tick();
    check_quiet("reset");
    reset = 1'b1;
    tick();

    run_cnt(2'b11, 0, 0, "t1");
    run_cnt(2'b11, 2, 3, "t2_stall");

    // LFSR run, 100 words per channel.
    bus.ch_enable = 2'b11;
    bus.mode      = 1'b1;
    bus.num_items = 16'd100;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("t3/seed0", 64'(ch_word(0)), 64'h0000_ACE0);
    check_eq("t3/seed1", 64'(ch_word(1)), 64'h0000_ACE3);
    w[0] = SEED ^ 32'd1;
    w[1] = SEED ^ 32'd2;
    for (int k = 0; k < 100; k++) begin
      check_eq("t3/valid", 64'(bus.in_valid), 64'd3);
      for (int ch = 0; ch < 2; ch++) begin
        check_eq("t3/lfsr", 64'(ch_word(ch)), 64'(w[ch]));
        w[ch] = lfsr_ref(w[ch]);
      end
      tick();
    end
    check_eq("t3/done", 64'(bus.done), 64'd1);
    tick();

    // Flush ch1 while its word 2 is stalled.
    bus.mode      = 1'b0;
    bus.num_items = 16'd4;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_eq("t4/pre_w1", 64'(ch_word(1)), 64'h0100_0002);
    bus.stall     = 1'b1;
    bus.flush_req = 2'b10;
    tick();
    bus.stall     = 1'b0;
    bus.flush_req = 2'b00;
    check_eq("t4/flush",     64'(bus.flush), 64'd2);
    check_eq("t4/valid",     64'(bus.in_valid), 64'd1);
    check_eq("t4/ch0_held",  64'(ch_word(0)), 64'h0000_0002);
    tick();
    check_eq("t4/flush_end", 64'(bus.flush), 64'd0);
    check_eq("t4/valid2",    64'(bus.in_valid), 64'd3);
    check_eq("t4/ch0_w3",    64'(ch_word(0)), 64'h0000_0003);
    for (int k = 0; k < 4; k++) begin
      check_eq("t4/ch1_word", 64'(ch_word(1)), 64'(cnt_word(1, k)));
      check_eq("t4/ch1_valid", 64'(bus.in_valid[1]), 64'd1);
      tick();
    end
    check_eq("t4/done", 64'(bus.done), 64'd1);
    check_eq("t4/busy", 64'(bus.busy), 64'd0);
    tick();

    run_cnt(2'b01, 0, 0, "t5_mask");

    // Zero-length run goes straight to DONE.
    bus.ch_enable = 2'b11;
    bus.num_items = 16'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("t5/zero_done",  64'(bus.done), 64'd1);
    check_eq("t5/zero_valid", 64'(bus.in_valid), 64'd0);
    check_eq("t5/zero_busy",  64'(bus.busy), 64'd0);
    tick();
    check_eq("t5/zero_idle",  64'(bus.done), 64'd0);

    // Reset mid-run under stall, then replay the first run.
    bus.num_items = 16'd4;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.stall = 1'b1;
    reset     = 1'b0;
    tick();
    tick();
    check_quiet("t6_reset");
    reset     = 1'b1;
    bus.stall = 1'b0;
    tick();
    check_quiet("t6_idle");
    run_cnt(2'b11, 0, 0, "t6_replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
